// File: rtl/music_sequencer.sv
// Score-ROM note sequencer: steps through a two-song score at a beat tempo and
// drives the left/right note dividers. Build option: MUSIC_SEQ_ARTIC_EN (articulation gap).
module music_sequencer #(
  parameter int unsigned BEAT_DIV = 25000000,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DIV_W    = 22,
  parameter int unsigned GAP_CYC  = 2500000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 play,
  input  logic                 pause,
  input  logic                 stop,
  input  logic                 song_sel,
  input  logic                 loop_en,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [2*DIV_W+3:0]   rom_data,
  output logic [DIV_W-1:0]     tune_left,
  output logic [DIV_W-1:0]     tune_right,
  output logic                 playing,
  output logic                 paused,
  output logic                 song_done,
  output logic [ADDR_W-2:0]    note_idx
);

  localparam int unsigned IDX_W  = ADDR_W - 1;
  localparam int unsigned BEAT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_DIV - 1);
  localparam logic [BEAT_W-1:0] GAP_START =
    BEAT_W'((GAP_CYC < BEAT_DIV) ? (BEAT_DIV - GAP_CYC) : 0);

`ifdef MUSIC_SEQ_ARTIC_EN
  localparam bit ARTIC_EN = 1'b1;
`else
  localparam bit ARTIC_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, NOTE, PAUSE, DONE} state_t;

  state_t            state, state_nxt, run_nxt, resume_state;
  logic              song;
  logic [IDX_W-1:0]  idx;
  logic [BEAT_W-1:0] beat_cnt;
  logic [3:0]        dur_cnt;
  logic [DIV_W-1:0]  div_l, div_r;
  logic [DIV_W-1:0]  ent_l, ent_r;
  logic [3:0]        ent_dur;
  logic              beat_wrap;
  logic              in_gap;

  assign ent_l     = rom_data[2*DIV_W+3 -: DIV_W];
  assign ent_r     = rom_data[DIV_W+3 -: DIV_W];
  assign ent_dur   = rom_data[3:0];
  assign beat_wrap = (beat_cnt == BEAT_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state always uses <=, so every register samples pre-edge values.
      state <= state_nxt;
    end
  end

  // run_nxt is where the song would go with no user intervention; a pause only
  // parks the machine in PAUSE and remembers run_nxt, so the pausing cycle
  // still counts as normal playback time.
  always_comb begin
    // NOTE: defaults first in every always_comb so no path can infer a latch.
    run_nxt = state;
    case (state)
      IDLE, DONE: if (play) run_nxt = FETCH;
      FETCH:      run_nxt = WAIT;
      WAIT: begin
        if (ent_dur == 4'd0) run_nxt = loop_en ? FETCH : DONE;
        else                 run_nxt = NOTE;
      end
      NOTE:  if (beat_wrap && dur_cnt == 4'd1) run_nxt = FETCH;
      PAUSE: if (play) run_nxt = resume_state;
      default: run_nxt = IDLE;
    endcase

    state_nxt = run_nxt;
    if (stop) begin
      state_nxt = IDLE;
    end else if (playing && pause && !play &&
                 (run_nxt == FETCH || run_nxt == WAIT || run_nxt == NOTE)) begin
      state_nxt = PAUSE;
    end
  end

  // Datapath: index, counters and held note registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resume_state <= IDLE;
      song         <= 1'b0;
      idx          <= '0;
      beat_cnt     <= '0;
      dur_cnt      <= '0;
      div_l        <= '0;
      div_r        <= '0;
      song_done    <= 1'b0;
    end else begin
      song_done <= 1'b0;
      if (stop) begin
        idx      <= '0;
        beat_cnt <= '0;
        dur_cnt  <= '0;
        div_l    <= '0;
        div_r    <= '0;
      end else begin
        if (state_nxt == PAUSE && state != PAUSE) resume_state <= run_nxt;
        case (state)
          IDLE, DONE: begin
            if (play) begin
              song  <= song_sel;
              idx   <= '0;
              div_l <= '0;
              div_r <= '0;
            end
          end
          WAIT: begin
            if (ent_dur == 4'd0) begin
              if (loop_en) idx <= '0;
              else         song_done <= 1'b1;
            end else begin
              div_l    <= ent_l;
              div_r    <= ent_r;
              dur_cnt  <= ent_dur;
              beat_cnt <= '0;
            end
          end
          NOTE: begin
            if (beat_wrap) begin
              beat_cnt <= '0;
              dur_cnt  <= dur_cnt - 4'd1;
              if (dur_cnt == 4'd1) idx <= idx + IDX_W'(1);
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs: tunes are gated by state so a reset or pause silences them at once.
  always_comb begin
    playing    = (state == FETCH) || (state == WAIT) || (state == NOTE);
    paused     = (state == PAUSE);
    in_gap     = ARTIC_EN && (state == NOTE) && (dur_cnt == 4'd1) && (beat_cnt >= GAP_START);
    tune_left  = (playing && !in_gap) ? div_l : '0;
    tune_right = (playing && !in_gap) ? div_r : '0;
    rom_addr   = {song, idx};
    note_idx   = idx;
  end

endmodule

// File: tb/tb_music_sequencer.sv
// Self-checking bench for music_sequencer: a per-note timeline model built from the
// score contents is compared cycle by cycle against the DUT outputs.
module tb_music_sequencer;

  localparam int BD    = 10;
  localparam int AW    = 7;
  localparam int DW    = 22;
  localparam int GAP   = 3;
  localparam int N_IDX = 64;

  logic clk = 1'b0, rst = 1'b1;
  logic play = 1'b0, pause = 1'b0, stop = 1'b0, song_sel = 1'b0, loop_en = 1'b0;
  logic [AW-1:0]     rom_addr;
  logic [2*DW+3:0]   rom_data;
  logic [DW-1:0]     tune_left, tune_right;
  logic              playing, paused, song_done;
  logic [AW-2:0]     note_idx;

  int checks = 0;
  int errors = 0;

  logic [2*DW+3:0] rom [2*N_IDX];

  typedef struct {
    logic          playing;
    logic [5:0]    idx;
    logic [DW-1:0] tl;
    logic [DW-1:0] tr;
    logic          done;
  } exp_t;

  exp_t trace[$];

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  music_sequencer #(.BEAT_DIV(BD), .ADDR_W(AW), .DIV_W(DW), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop),
    .song_sel(song_sel), .loop_en(loop_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .tune_left(tune_left), .tune_right(tune_right), .playing(playing), .paused(paused),
    .song_done(song_done), .note_idx(note_idx)
  );

  function automatic logic [2*DW+3:0] make_entry(input int l, input int r, input int d);
    return {l[DW-1:0], r[DW-1:0], d[3:0]};
  endfunction

  function automatic int rand_div();
    return ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, (1 << DW) - 1));
  endfunction

  // Timeline of one playback: each entry costs two fetch cycles (previous tune
  // held), then dur*BD cycles of its own tune; an end marker either ends the song
  // (one song_done cycle) or jumps back to entry 0.
  task automatic build_trace(input bit sel, input bit loop, input int max_entries);
    logic [DW-1:0]   prev_l, prev_r, dl, dr;
    logic [2*DW+3:0] ent;
    int              k, d;
    exp_t            e;
    prev_l = '0; prev_r = '0; k = 0;
    trace.delete();
    for (int n = 0; n < max_entries; n++) begin
      ent = rom[int'(sel) * N_IDX + k];
      dl  = ent[2*DW+3 -: DW];
      dr  = ent[DW+3 -: DW];
      d   = int'(ent[3:0]);
      e.playing = 1'b1; e.idx = 6'(k); e.tl = prev_l; e.tr = prev_r; e.done = 1'b0;
      trace.push_back(e);
      trace.push_back(e);
      if (d == 0) begin
        if (!loop) begin
          e.playing = 1'b0; e.tl = '0; e.tr = '0; e.done = 1'b1;
          trace.push_back(e);
          break;
        end
        k = 0;
      end else begin
        for (int c = 0; c < d * BD; c++) begin
          e.playing = 1'b1; e.idx = 6'(k); e.tl = dl; e.tr = dr; e.done = 1'b0;
`ifdef MUSIC_SEQ_ARTIC_EN
          if (c >= d * BD - GAP) begin e.tl = '0; e.tr = '0; end
`endif
          trace.push_back(e);
        end
        prev_l = dl; prev_r = dr;
        k = (k + 1) % N_IDX;
      end
    end
  endtask

  // Plays one song and checks every cycle against the timeline; optionally
  // inserts a pause of 'hold' cycles right after timeline cycle pause_at.
  task automatic play_and_check(input string tag, input bit sel, input bit loop,
                                input int max_entries, input int pause_at, input int hold);
    logic [59:0] got, want;
    exp_t        e, en;
    build_trace(sel, loop, max_entries);
    @(negedge clk); song_sel = sel; loop_en = loop; play = 1'b1;
    @(negedge clk); play = 1'b0;
    for (int t = 0; t < trace.size(); t++) begin
      e = trace[t];
      en.playing = 1'b0; en.idx = e.idx;
      if (t + 1 < trace.size()) en = trace[t+1];
      got  = {playing, paused, song_done, note_idx, rom_addr, tune_left, tune_right};
      want = {e.playing, 1'b0, e.done, e.idx, sel, e.idx, e.tl, e.tr};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h, expected %h", tag, t, got, want);
      end
      song_sel = 1'($urandom);
      loop_en  = (e.playing && !e.done) ? loop : 1'($urandom);
      if (t == pause_at && e.playing && en.playing && hold > 0) begin
        pause = 1'b1;
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          pause = 1'b0;
          got  = {playing, paused, song_done, note_idx, rom_addr, tune_left, tune_right};
          want = {1'b0, 1'b1, 1'b0, en.idx, sel, en.idx, {DW{1'b0}}, {DW{1'b0}}};
          checks++;
          if (got !== want) begin
            errors++;
            $display("FAIL %s paused %0d: got %h, expected %h", tag, h, got, want);
          end
          if (h == hold - 1) play = 1'b1;
          else               pause = 1'($urandom);
        end
        @(negedge clk); play = 1'b0; pause = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    loop_en = loop;
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    checks++;
    if ({playing, paused, note_idx, tune_left, tune_right} !== '0) begin
      errors++;
      $display("FAIL %s idle after stop: playing=%b paused=%b idx=%0d tune=%h/%h, expected all 0",
               tag, playing, paused, note_idx, tune_left, tune_right);
    end
  endtask

  task automatic load_single_note();
    for (int i = 0; i < 2 * N_IDX; i++) rom[i] = make_entry(0, 0, 0);
    rom[0] = make_entry(191571, 191571, 2);
    rom[1] = make_entry(0, 0, 0);
  endtask

  task automatic fill_random_song(input bit s, input int len);
    for (int i = 0; i < N_IDX; i++)
      rom[int'(s) * N_IDX + i] = make_entry(rand_div(), rand_div(),
                                            (i == len) ? 0 : int'($urandom_range(1, 3)));
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2 * N_IDX; i++) rom[i] = '0;
    #2;
    checks++;
    if ({tune_left, tune_right, rom_addr, note_idx, playing, paused, song_done} !== '0) begin
      errors++;
      $display("FAIL reset_hold: outputs %h, expected 0",
               {tune_left, tune_right, rom_addr, note_idx, playing, paused, song_done});
    end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({tune_left, tune_right, rom_addr, note_idx, playing, paused, song_done} !== '0) begin
      errors++;
      $display("FAIL reset_release: outputs %h, expected 0",
               {tune_left, tune_right, rom_addr, note_idx, playing, paused, song_done});
    end
  endtask

  task automatic test_single_note();
    load_single_note();
    play_and_check("single_note", 1'b0, 1'b0, 4, -1, 0);
  endtask

  task automatic test_loop();
    load_single_note();
    play_and_check("loop", 1'b0, 1'b1, 5, -1, 0);
  endtask

  task automatic test_pause();
    load_single_note();
    play_and_check("pause_mid_note", 1'b0, 1'b0, 4, 9, 50);
  endtask

  task automatic test_stop_play();
    load_single_note();
    @(negedge clk); song_sel = 1'b0; loop_en = 1'b0; play = 1'b1;
    @(negedge clk); play = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (tune_left !== DW'(191571) || playing !== 1'b1) begin
      errors++;
      $display("FAIL stop_play pre: tune=%0d playing=%b, expected 191571 and 1", tune_left, playing);
    end
    stop = 1'b1; play = 1'b1; pause = 1'b1;
    @(negedge clk); stop = 1'b0; play = 1'b0; pause = 1'b0;
    checks++;
    if ({playing, paused, note_idx, tune_left, tune_right} !== '0) begin
      errors++;
      $display("FAIL stop_play idle: playing=%b paused=%b idx=%0d tune=%0d, expected all 0",
               playing, paused, note_idx, tune_left);
    end
    play_and_check("restart_after_stop", 1'b0, 1'b0, 4, -1, 0);
  endtask

  task automatic test_song_sel();
    fill_random_song(1'b0, 3);
    fill_random_song(1'b1, 4);
    play_and_check("song1", 1'b1, 1'b0, 8, -1, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      bit s, lp;
      s  = 1'($urandom);
      lp = 1'($urandom);
      fill_random_song(1'b0, int'($urandom_range(1, 6)));
      fill_random_song(1'b1, int'($urandom_range(1, 6)));
      play_and_check($sformatf("random%0d", r), s, lp, 16,
                     int'($urandom_range(0, 60)), int'($urandom_range(1, 8)));
    end
  endtask

  task automatic test_index_wrap();
    for (int i = 0; i < N_IDX; i++) rom[N_IDX + i] = make_entry(rand_div(), rand_div(), 1);
    play_and_check("index_wrap", 1'b1, 1'b0, 66, -1, 0);
  endtask

  task automatic test_reset_mid_note();
    load_single_note();
    @(negedge clk); song_sel = 1'b0; loop_en = 1'b0; play = 1'b1;
    @(negedge clk); play = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({tune_left, tune_right, playing, note_idx} !== '0) begin
      errors++;
      $display("FAIL reset_mid_note: tune=%0d/%0d playing=%b idx=%0d, expected all 0",
               tune_left, tune_right, playing, note_idx);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({tune_left, playing, paused, song_done} !== '0) begin
      errors++;
      $display("FAIL reset_mid_note after: tune=%0d playing=%b, expected 0", tune_left, playing);
    end
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_loop();
    test_pause();
    test_stop_play();
    test_song_sel();
    test_random();
    test_index_wrap();
    test_reset_mid_note();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/music_sequencer.md
Name: music_sequencer

Overview:
- Sequences note playback for the music player.
- Steps through a score ROM at a programmable tempo and drives the left/right note dividers consumed by buzzer_control.
- Handles play/pause/stop, two-song selection and looping.
- Sits between the user-input debouncers and buzzer_control; replaces fixed-tempo music selection.

Parameters:
- BEAT_DIV, 25000000, clk cycles per beat unit (0.25 s at 100 MHz).
- ADDR_W, 7, score address width; each song holds 2^(ADDR_W-1) = 64 entries.
- DIV_W, 22, note divider width.
- GAP_CYC, 2500000, silence cycles at the end of each note (optional feature only).

Ports:
- clk  in  1  system clock (100 MHz crystal).
- rst  in  1  asynchronous, active-high reset.
- play  in  1  one-cycle pulse: start, or resume from pause.
- pause  in  1  one-cycle pulse: freeze the current note.
- stop  in  1  one-cycle pulse: abort playback and return to idle.
- song_sel  in  1  song index, sampled only on play from IDLE/DONE.
- loop_en  in  1  restart the song at its end instead of stopping.
- rom_addr  out  ADDR_W  score address = {song, idx[ADDR_W-2:0]}.
- rom_data  in  2*DIV_W+4  {div_left, div_right, dur[3:0]}; valid 1 cycle after rom_addr changes.
- tune_left  out  DIV_W  left note divider; 0 = silence.
- tune_right  out  DIV_W  right note divider; 0 = silence.
- playing  out  1  high in FETCH/WAIT/NOTE.
- paused  out  1  high in PAUSE.
- song_done  out  1  one-cycle pulse when a song ends without looping.
- note_idx  out  ADDR_W-1  current entry index.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: tune_left/right=0, rom_addr=0, note_idx=0, playing=0, paused=0, song_done=0, state=IDLE, beat counter=0, duration counter=0.
- States: IDLE, FETCH, WAIT, NOTE, PAUSE, DONE.
- IDLE:
  - Outputs silent.
  - play: latch song_sel, idx=0, go to FETCH.
  - pause and stop are ignored.
- FETCH: drive rom_addr, go to WAIT (one cycle).
- WAIT: register rom_data.
  - dur==0 is the end marker:
    - loop_en=1: idx=0, go to FETCH.
    - loop_en=0: pulse song_done, go to DONE.
  - dur!=0: load tune_left/right from the entry, dur_cnt=dur, beat_cnt=0, go to NOTE.
- NOTE:
  - beat_cnt counts 0..BEAT_DIV-1.
  - At the wrap: dur_cnt decrements. At dur_cnt 1->0, idx+1, go to FETCH.
  - A note therefore lasts dur*BEAT_DIV cycles, plus 2 cycles of fetch overhead during which tune holds the previous value.
- Index wrap: idx wraps from 63 to 0 when no end marker is present; this is treated as a normal continuation, not an end.
- PAUSE:
  - Entered from NOTE/FETCH/WAIT on pause. Counters are frozen and tune outputs are forced to 0.
  - play resumes to the same state, with tune restored from the held registers.
  - pause in PAUSE is ignored.
- DONE: outputs silent; play restarts as from IDLE.
- stop in any state: go to IDLE next cycle, tune=0, counters cleared. stop has priority over play and pause in the same cycle; play has priority over pause.
- Rests: an entry with div=0 and dur!=0 is a timed rest on that channel.
- song_sel and loop_en changes are ignored mid-song. loop_en is sampled at the end marker.
- A reset asserted mid-note silences the outputs immediately (asynchronously).

Optional Feature:
- Macro: MUSIC_SEQ_ARTIC_EN.
- Defined: during the last GAP_CYC cycles of each note's final beat (dur_cnt==1 and beat_cnt >= BEAT_DIV-GAP_CYC), tune_left/right=0. This makes repeated identical notes audibly separate. Note timing is unchanged.
- Undefined: tunes are held for the full duration, and GAP_CYC is unused.

Test Plan:
- Reset then play, song_sel=0, ROM[0]={191571,191571,2}, ROM[1] dur=0, BEAT_DIV=10 -> tune=191571 for exactly 20 cycles after WAIT, then song_done pulses once, state DONE, tune=0.
- Same song with loop_en=1 -> no song_done; rom_addr returns to 0 and tune=191571 reappears 2 cycles after the end marker.
- Pause at cycle 7 of a dur=2 note, hold 50 cycles, then play -> tune=0 during pause; the note resumes for the remaining 13 cycles; total note time = 20 cycles excluding pause.
- stop and play in the same cycle during NOTE -> IDLE, tune=0, playing=0; the next play restarts from idx 0.
- song_sel=1 on play -> rom_addr=64; toggling song_sel mid-song leaves rom_addr within 64..127.
- MUSIC_SEQ_ARTIC_EN defined, GAP_CYC=3, BEAT_DIV=10, dur=1 -> tune nonzero for 7 cycles, then 0 for 3 cycles, then next fetch.
